// File: rtl/parity_arb.sv
// Round-robin arbiter sharing one XOR-reduction parity unit among R requesters.
// Define PARITY_ARB_ODD_EN to report odd parity instead of even parity.
module parity_arb #(
    parameter int N = 8,
    parameter int R = 4,
    parameter int W = $clog2(R)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] data,
    output logic [R-1:0]   gnt,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_par,
    output logic [W-1:0]   out_id
);

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t         state, state_d;
    logic [W-1:0]   ptr, ptr_d;
    logic [W-1:0]   id, id_d;
    logic [W-1:0]   out_id_d;
    logic [N-1:0]   opnd, opnd_d;
    logic [R-1:0]   gnt_d;
    logic           out_valid_d, out_par_d;
    logic           found;
    logic [W-1:0]   win;
    logic           par;

    // Index ptr+i folded back into 0..R-1 without a divider.
    function automatic logic [W-1:0] wrap(input int v);
        return (v >= R) ? W'(v - R) : W'(v);
    endfunction

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < R; i++) begin
            if (!found && req[wrap(int'(ptr) + i)]) begin
                found = 1'b1;
                win   = wrap(int'(ptr) + i);
            end
        end
    end

`ifdef PARITY_ARB_ODD_EN
    assign par = ~^opnd;
`else
    assign par = ^opnd;
`endif

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        id_d        = id;
        opnd_d      = opnd;
        gnt_d       = '0;
        out_valid_d = out_valid;
        out_par_d   = out_par;
        out_id_d    = out_id;
        unique case (state)
            IDLE: begin
                if (found) begin
                    opnd_d  = data[win*N +: N];
                    id_d    = win;
                    gnt_d   = R'(1) << win;
                    state_d = CALC;
                end
            end
            CALC: begin
                out_par_d   = par;
                out_id_d    = id;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ptr_d       = (id == W'(R - 1)) ? '0 : id + W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            id        <= '0;
            opnd      <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            out_par   <= 1'b0;
            out_id    <= '0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            id        <= id_d;
            opnd      <= opnd_d;
            gnt       <= gnt_d;
            out_valid <= out_valid_d;
            out_par   <= out_par_d;
            out_id    <= out_id_d;
        end
    end

endmodule

// File: tb/tb_parity_arb.sv
// Directed self-checking bench for parity_arb (R=4 and R=3 instances).
// Build with PARITY_ARB_ODD_EN to check the odd-parity variant.
module tb_parity_arb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        ov, ordy, par;
    logic [1:0]  oid;

    logic [2:0]  req3;
    logic [23:0] data3;
    logic [2:0]  gnt3;
    logic        ov3, ordy3, par3;
    logic [1:0]  oid3;

    int errs = 0;
    int checks = 0;

`ifdef PARITY_ARB_ODD_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    // even parity of 8'h01, 8'h03, 8'h07, 8'h0F
    logic pe [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    parity_arb #(.N(8), .R(4)) u_dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt),
        .out_valid(ov), .out_ready(ordy), .out_par(par), .out_id(oid)
    );

    parity_arb #(.N(8), .R(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3), .data(data3), .gnt(gnt3),
        .out_valid(ov3), .out_ready(ordy3), .out_par(par3), .out_id(oid3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req = '0; data = '0; ordy = 1'b0;
        req3 = '0; data3 = '0; ordy3 = 1'b1;
        tick; tick;
        check("rst gnt", 32'(gnt), 32'(0));
        check("rst ov", 32'(ov), 32'(0));
        check("rst par", 32'(par), 32'(0));
        check("rst oid", 32'(oid), 32'(0));
        check("rst gnt3", 32'(gnt3), 32'(0));
        check("rst ov3", 32'(ov3), 32'(0));
        rst = 1'b0;

        // single request, consumer stalls
        req = 4'b0100; data[23:16] = 8'hB5;
        tick;
        check("t1 gnt", 32'(gnt), 32'(4'b0100));
        check("t1 ov early", 32'(ov), 32'(0));
        req = '0;
        tick;
        check("t1 gnt off", 32'(gnt), 32'(0));
        check("t1 ov", 32'(ov), 32'(1));
        check("t1 par", 32'(par), 32'(1'b1 ^ ODD));
        check("t1 oid", 32'(oid), 32'(2));
        for (int i = 0; i < 5; i++) begin
            tick;
            check("t1 hold ov", 32'(ov), 32'(1));
            check("t1 hold par", 32'(par), 32'(1'b1 ^ ODD));
            check("t1 hold oid", 32'(oid), 32'(2));
        end
        ordy = 1'b1;
        tick;
        check("t1 ov clr", 32'(ov), 32'(0));

        // round robin with all requesters active
        rst = 1'b1;
        tick;
        rst = 1'b0;
        req = 4'b1111;
        data = {8'h0F, 8'h07, 8'h03, 8'h01};
        for (int g = 0; g < 5; g++) begin
            int k;
            k = g % 4;
            tick;
            check("rr gnt", 32'(gnt), 32'(1) << k);
            check("rr ov calc", 32'(ov), 32'(0));
            tick;
            check("rr ov", 32'(ov), 32'(1));
            check("rr oid", 32'(oid), 32'(k));
            check("rr par", 32'(par), 32'(pe[k] ^ ODD));
            check("rr gnt hold", 32'(gnt), 32'(0));
            tick;
            check("rr ov idle", 32'(ov), 32'(0));
            check("rr gnt idle", 32'(gnt), 32'(0));
        end
        req = '0;

        // R=3 pointer wrap
        req3 = 3'b100;
        data3 = {8'hFF, 8'h03, 8'h01};
        tick;
        check("w gnt2", 32'(gnt3), 32'(3'b100));
        req3 = 3'b011;
        tick;
        check("w ov", 32'(ov3), 32'(1));
        check("w oid2", 32'(oid3), 32'(2));
        check("w par2", 32'(par3), 32'(1'b0 ^ ODD));
        tick;
        check("w ov idle", 32'(ov3), 32'(0));
        tick;
        check("w gnt0", 32'(gnt3), 32'(3'b001));
        tick;
        check("w oid0", 32'(oid3), 32'(0));
        check("w par0", 32'(par3), 32'(1'b1 ^ ODD));
        tick;
        tick;
        check("w gnt1", 32'(gnt3), 32'(3'b010));
        tick;
        check("w oid1", 32'(oid3), 32'(1));
        check("w par1", 32'(par3), 32'(1'b0 ^ ODD));
        tick;
        tick;
        check("w gnt0b", 32'(gnt3), 32'(3'b001));
        req3 = '0;

        // data and req change after grant
        req = 4'b0010; data[15:8] = 8'h03;
        tick;
        check("m gnt", 32'(gnt), 32'(4'b0010));
        data[15:8] = 8'h01; req = '0;
        tick;
        check("m ov", 32'(ov), 32'(1));
        check("m oid", 32'(oid), 32'(1));
        check("m par", 32'(par), 32'(1'b0 ^ ODD));
        tick;
        check("m ov clr", 32'(ov), 32'(0));

        // reset while holding a result
        ordy = 1'b0; req = 4'b0100; data[23:16] = 8'hB5;
        tick;
        check("r gnt", 32'(gnt), 32'(4'b0100));
        req = '0;
        tick;
        check("r ov hold", 32'(ov), 32'(1));
        rst = 1'b1;
        tick;
        check("r ov", 32'(ov), 32'(0));
        check("r gnt0", 32'(gnt), 32'(0));
        check("r par", 32'(par), 32'(0));
        check("r oid", 32'(oid), 32'(0));
        rst = 1'b0; req = 4'b1010; ordy = 1'b1;
        tick;
        check("r gnt after", 32'(gnt), 32'(4'b0010));
        req = '0;
        tick;
        tick;

        // all-zero and all-one operands
        req = 4'b0001; data[7:0] = 8'h00;
        tick;
        check("o gnt00", 32'(gnt), 32'(4'b0001));
        req = '0;
        tick;
        check("o par00", 32'(par), 32'(ODD));
        tick;
        req = 4'b0001; data[7:0] = 8'hFF;
        tick;
        check("o gntff", 32'(gnt), 32'(4'b0001));
        req = '0;
        tick;
        check("o parff", 32'(par), 32'(ODD));
        tick;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
